// File: rtl/vote_ballot_ctrl_if.sv
// Bus between a ballot controller and its voter stations / supervisor.
// start is a one-cycle request with no ready: it is acted on only in IDLE or
// RESULT and silently dropped otherwise; vote strobes are sampled every cycle.
interface vote_ballot_ctrl_if;
  logic       start;
  logic [4:0] vote_yes;
  logic [4:0] vote_no;
  logic       busy;
  logic       window_open;
  logic [4:0] voted;
  logic [2:0] yes_cnt;
  logic       pass;
  logic       timed_out;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output start, vote_yes, vote_no,
    input  busy, window_open, voted, yes_cnt, pass, timed_out, done, state_dbg
  );

  modport slave (
    input  start, vote_yes, vote_no,
    output busy, window_open, voted, yes_cnt, pass, timed_out, done, state_dbg
  );
endinterface

// File: rtl/vote_ballot_ctrl.sv
// Five-voter ballot controller: opens a timed window, latches one vote per
// voter, tallies the yes votes serially and publishes the majority decision.
module vote_ballot_ctrl #(
  parameter int WINDOW_CYCLES  = 1000,
  parameter int PASS_THRESHOLD = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  vote_ballot_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    TALLY  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LOAD = 16'(WINDOW_CYCLES - 1);
  localparam logic [2:0]  THRESHOLD  = 3'(PASS_THRESHOLD);

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  k, k_n;
  logic [4:0]  yes_r, yes_n;
  logic [4:0]  voted_r, voted_n;
  logic [2:0]  cnt_r, cnt_n;
  logic        pass_r, pass_n;
  logic        to_r, to_n;
  logic        done_r, done_n;
  logic [4:0]  acc_yes, acc_no;

  // A voter's strobe counts only if exactly one of yes/no is high and the
  // voter has not voted yet; both high means "try again next cycle".
  assign acc_yes = bus.vote_yes & ~bus.vote_no & ~voted_r;
  assign acc_no  = bus.vote_no & ~bus.vote_yes & ~voted_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      k       <= '0;
      yes_r   <= '0;
      voted_r <= '0;
      cnt_r   <= '0;
      pass_r  <= 1'b0;
      to_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      k       <= k_n;
      yes_r   <= yes_n;
      voted_r <= voted_n;
      cnt_r   <= cnt_n;
      pass_r  <= pass_n;
      to_r    <= to_n;
      done_r  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    k_n     = k;
    yes_n   = yes_r;
    voted_n = voted_r;
    cnt_n   = cnt_r;
    pass_n  = pass_r;
    to_n    = to_r;
    done_n  = 1'b0;
    case (state)
      IDLE, RESULT: begin
        if (bus.start) begin
          state_n = OPEN;
          timer_n = TIMER_LOAD;
          k_n     = '0;
          yes_n   = '0;
          voted_n = '0;
          cnt_n   = '0;
          pass_n  = 1'b0;
          to_n    = 1'b0;
        end
      end
      OPEN: begin
        voted_n = voted_r | acc_yes | acc_no;
        yes_n   = yes_r | acc_yes;
        // Full participation wins over an expiring timer in the same cycle.
        if (&voted_n) begin
          state_n = TALLY;
          to_n    = 1'b0;
          k_n     = '0;
        end else if (timer == '0) begin
          state_n = TALLY;
          to_n    = 1'b1;
          k_n     = '0;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      TALLY: begin
        cnt_n = cnt_r + {2'b00, yes_r[k]};
        if (k == 3'd4) begin
          state_n = RESULT;
          done_n  = 1'b1;
          pass_n  = (cnt_n >= THRESHOLD);
        end else begin
          k_n = k + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy        = (state == OPEN) || (state == TALLY);
  assign bus.window_open = (state == OPEN);
  assign bus.voted       = voted_r;
  assign bus.yes_cnt     = cnt_r;
  assign bus.pass        = pass_r;
  assign bus.timed_out   = to_r;
  assign bus.done        = done_r;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
// Directed and randomized ballots for vote_ballot_ctrl, checked against a
// per-voter reference model of the ballot rules.
module tb_vote_ballot_ctrl;
  localparam int W = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [4:0] sy[W];
  logic [4:0] sn[W];

  vote_ballot_ctrl_if bus ();

  vote_ballot_ctrl #(.WINDOW_CYCLES(W), .PASS_THRESHOLD(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  16'(bus.busy), 16'd0);
    check({tag, "_win"},   16'(bus.window_open), 16'd0);
    check({tag, "_voted"}, 16'(bus.voted), 16'd0);
    check({tag, "_cnt"},   16'(bus.yes_cnt), 16'd0);
    check({tag, "_pass"},  16'(bus.pass), 16'd0);
    check({tag, "_to"},    16'(bus.timed_out), 16'd0);
    check({tag, "_done"},  16'(bus.done), 16'd0);
  endtask

  task automatic clear_votes();
    for (int c = 0; c < W; c++) begin
      sy[c] = '0;
      sn[c] = '0;
    end
  endtask

  // Reference: each voter's ballot is its first window cycle with exactly one
  // strobe; the window closes on full participation or after W cycles.
  task automatic model(output int close_idx, output logic to,
                       output logic [4:0] v, output logic [4:0] y);
    v = '0;
    y = '0;
    close_idx = W - 1;
    to = 1'b1;
    for (int c = 0; c < W; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (!v[i] && (sy[c][i] != sn[c][i])) begin
          v[i] = 1'b1;
          y[i] = sy[c][i];
        end
      end
      if (v == 5'h1f) begin
        close_idx = c;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_ballot(input string tag, input bit inj);
    int         close_idx;
    int         got;
    int         cnt;
    logic       to;
    logic [4:0] v;
    logic [4:0] y;
    model(close_idx, to, v, y);
    cnt = $countones(y);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, "_open_win"},   16'(bus.window_open), 16'd1);
    check({tag, "_open_voted"}, 16'(bus.voted), 16'd0);
    check({tag, "_open_cnt"},   16'(bus.yes_cnt), 16'd0);
    check({tag, "_open_pass"},  16'(bus.pass), 16'd0);
    check({tag, "_open_to"},    16'(bus.timed_out), 16'd0);
    got = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.done) begin
        got = cyc;
        break;
      end
      check({tag, "_win_cyc"},  16'(bus.window_open), 16'(cyc <= close_idx));
      check({tag, "_busy_cyc"}, 16'(bus.busy), 16'(cyc <= close_idx + 5));
      bus.vote_yes = (cyc < W) ? sy[cyc] : 5'h00;
      bus.vote_no  = (cyc < W) ? sn[cyc] : 5'h00;
      bus.start    = inj && ((cyc == 1 && close_idx >= 1) || cyc == close_idx + 3);
      step();
    end
    bus.vote_yes = '0;
    bus.vote_no  = '0;
    bus.start    = 1'b0;
    check({tag, "_done_lat"}, 16'(got), 16'(close_idx + 6));
    check({tag, "_cnt"},   16'(bus.yes_cnt), 16'(cnt));
    check({tag, "_pass"},  16'(bus.pass), 16'(cnt >= 3));
    check({tag, "_to"},    16'(bus.timed_out), 16'(to));
    check({tag, "_voted"}, 16'(bus.voted), 16'(v));
    check({tag, "_busy"},  16'(bus.busy), 16'd0);
    step();
    check({tag, "_done_pulse"}, 16'(bus.done), 16'd0);
    check({tag, "_cnt_hold"},   16'(bus.yes_cnt), 16'(cnt));
    check({tag, "_voted_hold"}, 16'(bus.voted), 16'(v));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.vote_yes = '0;
    bus.vote_no = '0;
    step();
    step();
    check_zero("reset");
    check("reset_state", 16'(bus.state_dbg), 16'd0);
    #2 rst_n = 1'b1;
    step();
    check_zero("idle");

    // Three yes then two no, one voter per cycle.
    clear_votes();
    sy[0] = 5'h01; sy[1] = 5'h02; sy[2] = 5'h04; sn[3] = 5'h08; sn[4] = 5'h10;
    run_ballot("seq", 1'b0);

    // Everyone in one cycle.
    clear_votes();
    sy[0] = 5'h03; sn[0] = 5'h1c;
    run_ballot("burst", 1'b0);

    // Only voter 4 votes; window times out.
    clear_votes();
    sy[2] = 5'h10;
    run_ballot("timeout", 1'b0);

    // Voter 0: conflict, then no, then yes; the no is final.
    clear_votes();
    sy[0] = 5'h01; sn[0] = 5'h01; sn[1] = 5'h01; sy[2] = 5'h01; sy[3] = 5'h1e;
    run_ballot("conflict", 1'b0);

    // Restart attempts during OPEN and TALLY must be ignored.
    clear_votes();
    sy[0] = 5'h01; sy[1] = 5'h02; sy[2] = 5'h04; sn[3] = 5'h08; sn[4] = 5'h10;
    run_ballot("inj", 1'b1);

    // Asynchronous reset while tallying at k=2.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.vote_yes = 5'h1f;
    step();
    bus.vote_yes = '0;
    step();
    step();
    check("rst_pre_tally", 16'(bus.busy), 16'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    step();
    step();
    check_zero("rst_hold");
    #3 rst_n = 1'b1;
    step();
    check_zero("rst_release");
    clear_votes();
    sy[0] = 5'h03; sn[0] = 5'h1c;
    run_ballot("post_rst", 1'b0);

    // Randomized ballots with sparse strobes and random restart attempts.
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < W; c++) begin
        sy[c] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
        sn[c] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
      end
      run_ballot("rand", 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
